audio_fifo_wb: RTL

- Wishbone-writable stereo sample FIFO that feeds the S/PDIF encoder's sample input (audio_l/audio_r/valid/ack).
- Replaces the free-running on-chip tone source, so the host can stream PCM over the USB-to-Wishbone bridge.
- Wishbone slave side uses the codebase's light bus: cyc-as-strobe, single-cycle ack, and rdata that is zero when not acking.
- Sample side pops one stereo pair per encoder ack.

---
 rtl/audio_fifo_wb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/audio_fifo_wb.sv
// Wishbone-writable stereo PCM FIFO feeding the S/PDIF encoder sample port.
// Show-ahead: block-RAM read stage plus a head register that holds the pair on offer.
module audio_fifo_wb #(
    parameter int DEPTH_LOG2 = 9,
    parameter int SAMPLE_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            wb_addr,
    input  logic [31:0]           wb_wdata,
    output logic [31:0]           wb_rdata,
    input  logic                  wb_we,
    input  logic                  wb_cyc,
    output logic                  wb_ack,
    output logic [23:0]           audio_l,
    output logic [23:0]           audio_r,
    output logic                  valid,
    input  logic                  ack,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PAIR_W = 2 * SAMPLE_W;

    logic                  wb_ack_q, wb_ack_d;
    logic [31:0]           wb_rdata_q, wb_rdata_d;
    logic                  enable_q, enable_d;
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  head_vld_q, head_vld_d;
    logic [PAIR_W-1:0]     head_q, head_d;
    logic [PAIR_W-1:0]     rd_data_q;
    logic [PAIR_W-1:0]     mem_q [DEPTH];

    logic                  bus_go, csr_wr, data_wr, flush;
    logic                  enc_ack, pop, push_ok, full;
    logic [SAMPLE_W-1:0]   push_l, push_r;

    // Ack is registered and forced low after each pulse, so a held cyc yields one ack every other cycle.
    assign bus_go  = wb_cyc & ~wb_ack_q;
    assign csr_wr  = bus_go & wb_we & (wb_addr == 2'd0);
    assign data_wr = bus_go & wb_we & (wb_addr == 2'd1);
    assign flush   = csr_wr & wb_wdata[1];
    assign enc_ack = ack & enable_q & ~flush;
    assign pop     = enc_ack & head_vld_q;
    assign full    = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign push_ok = data_wr & (~full | pop);

    generate
        if (SAMPLE_W >= 16) begin : g_pad
            assign push_l = SAMPLE_W'(wb_wdata[31:16]) << (SAMPLE_W - 16);
            assign push_r = SAMPLE_W'(wb_wdata[15:0]) << (SAMPLE_W - 16);
        end else begin : g_trunc
            assign push_l = SAMPLE_W'(wb_wdata[31:16] >> (16 - SAMPLE_W));
            assign push_r = SAMPLE_W'(wb_wdata[15:0] >> (16 - SAMPLE_W));
        end
    endgenerate

    always_comb begin
        wb_ack_d   = bus_go;
        wb_rdata_d = '0;
        enable_d   = enable_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        head_vld_d = head_vld_q;
        head_d     = head_q;
        // The RAM output is only trusted when its address was stable and the slot written earlier.
        rd_vld_d   = (level_q != '0) & ~pop;

        if (bus_go & ~wb_we & (wb_addr == 2'd0))
            wb_rdata_d = {16'(level_q), 12'd0, overflow_q, underrun_q, 1'b0, enable_q};

        if (csr_wr) begin
            enable_d = wb_wdata[0];
            if (wb_wdata[2]) underrun_d = 1'b0;
            if (wb_wdata[3]) overflow_d = 1'b0;
        end
        if (enc_ack & ~head_vld_q)  underrun_d = 1'b1;
        if (data_wr & ~push_ok)     overflow_d = 1'b1;

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (pop) begin
            head_vld_d = 1'b0;
        end else if (~head_vld_q & rd_vld_q) begin
            head_vld_d = 1'b1;
            head_d     = rd_data_q;
        end

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            head_vld_d = 1'b0;
            rd_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_q   <= 1'b0;
            wb_rdata_q <= '0;
            enable_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_vld_q   <= 1'b0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wb_ack_q   <= wb_ack_d;
            wb_rdata_q <= wb_rdata_d;
            enable_q   <= enable_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_vld_q   <= rd_vld_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {push_l, push_r};
        rd_data_q <= mem_q[rd_ptr_q];
    end

    assign wb_ack   = wb_ack_q;
    assign wb_rdata = wb_rdata_q;
    assign level    = level_q;
    assign valid    = enable_q & head_vld_q;
    assign audio_l  = valid ? (24'(head_q[PAIR_W-1 -: SAMPLE_W]) << (24 - SAMPLE_W)) : 24'd0;
    assign audio_r  = valid ? (24'(head_q[SAMPLE_W-1:0]) << (24 - SAMPLE_W)) : 24'd0;

endmodule
